daq_acq_sequencer: RTL

// Sequences the ADC sampling loop: issues paced CONVST pulses, waits for BUSY to fall, and reads NUM_CH words

---
 rtl/daq_pkg.sv | 27 ++
 rtl/daq_rd_strobe.sv | 46 ++++
 rtl/daq_acq_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/daq_pkg.sv
// Shared types and defaults for the ADC acquisition sequencer.
// State encoding, pin level names and default timing counts.
package daq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CONVERT,
        ST_WAIT_BUSY,
        ST_READ,
        ST_PUSH
    } state_t;

    localparam logic HI = 1'b1;
    localparam logic LO = 1'b0;

    localparam int DEF_PERIOD_CYCLES   = 1000;
    localparam int DEF_CONV_LOW_CYCLES = 10;
    localparam int DEF_RD_LOW_CYCLES   = 2;
    localparam int DEF_BUSY_TIMEOUT    = 4095;

    // Bits needed to count 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/daq_rd_strobe.sv
// Per-word ADC read strobe: holds rd_n low for RD_LOW_CYCLES after go,
// flags the final low cycle for data capture, then pulses done.
module daq_rd_strobe
    import daq_pkg::*;
#(
    parameter int RD_LOW_CYCLES = DEF_RD_LOW_CYCLES
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clr_i,
    input  logic go_i,
    output logic rd_n_o,
    output logic cap_o,
    output logic done_o
);

    localparam int RW = cnt_width(RD_LOW_CYCLES);

    logic          active_q;
    logic [RW-1:0] cnt_q;
    logic          done_q;

    assign cap_o  = active_q && (cnt_q == RW'(RD_LOW_CYCLES - 1));
    assign rd_n_o = active_q ? LO : HI;
    assign done_o = done_q;

    // Strobe timer; done follows capture by one cycle, when rd_n is high again.
    always_ff @(posedge clk_i) begin
        if (reset_i || clr_i) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= cap_o;
            if (go_i) begin
                active_q <= 1'b1;
                cnt_q    <= '0;
            end else if (cap_o) begin
                active_q <= 1'b0;
            end else if (active_q) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/daq_acq_sequencer.sv
// ADC sampling loop sequencer: paced CONVST, BUSY wait, CS/RD word reads, stream out.
// Optional DAQ_FRAME_HDR_EN prepends a {1'b1, frame_count} header word to every frame.
module daq_acq_sequencer
    import daq_pkg::*;
#(
    parameter int NUM_CH          = 8,
    parameter int DATA_W          = 16,
    parameter int PERIOD_CYCLES   = DEF_PERIOD_CYCLES,
    parameter int CONV_LOW_CYCLES = DEF_CONV_LOW_CYCLES,
    parameter int RD_LOW_CYCLES   = DEF_RD_LOW_CYCLES,
    parameter int BUSY_TIMEOUT    = DEF_BUSY_TIMEOUT
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              en_i,
    input  logic              start_i,
    input  logic [15:0]       burst_len_i,
    output logic              conv_o,
    input  logic              busy_i,
    output logic              cs_n_o,
    output logic              rd_n_o,
    input  logic [DATA_W-1:0] adc_data_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic              m_last_o,
    output logic              running_o,
    output logic              done_o,
    output logic              overrun_o,
    output logic              timeout_o
);

    localparam int PW   = cnt_width(PERIOD_CYCLES);
    localparam int CMAX = (BUSY_TIMEOUT > CONV_LOW_CYCLES) ? BUSY_TIMEOUT : CONV_LOW_CYCLES;
    localparam int CW   = cnt_width(CMAX);
    localparam int CHW  = cnt_width(NUM_CH);

    state_t            state_q, state_d;
    logic [PW-1:0]     per_q;
    logic              force_q;
    logic [CW-1:0]     cnt_q;
    logic [CHW-1:0]    ch_q;
    logic [15:0]       burst_q;
    logic [15:0]       frame_q;
    logic              hdr_q;
    logic [DATA_W-1:0] data_q;
    logic              last_q;
    logic              running_q;
    logic              done_q;
    logic              overrun_q;
    logic              timeout_q;

    logic        tick, conv_end, busy_ok, busy_to;
    logic        accept, word_last, frame_end, burst_end, start_ok;
    logic [15:0] frame_nxt;
    logic        rd_go, rd_n, rd_cap_raw, rd_done_raw, rd_cap, rd_done;

    assign tick      = running_q && (force_q || per_q == PW'(PERIOD_CYCLES - 1));
    assign conv_end  = (state_q == ST_CONVERT) && (cnt_q == CW'(CONV_LOW_CYCLES - 1));
    assign busy_ok   = (state_q == ST_WAIT_BUSY) && (cnt_q >= CW'(2)) && !busy_i;
    assign busy_to   = (state_q == ST_WAIT_BUSY) && !busy_ok && (cnt_q == CW'(BUSY_TIMEOUT - 1));
    assign accept    = (state_q == ST_PUSH) && m_ready_i;
    assign word_last = !hdr_q && (ch_q == CHW'(NUM_CH - 1));
    assign frame_end = accept && word_last;
    assign frame_nxt = frame_q + 16'd1;
    assign burst_end = frame_end && (burst_q != '0) && (frame_nxt == burst_q);
    assign start_ok  = (state_q == ST_IDLE) && start_i && en_i;
    assign rd_go     = en_i && (state_d == ST_READ) && (state_q != ST_READ);
    assign rd_cap    = (state_q == ST_READ) && rd_cap_raw;
    assign rd_done   = (state_q == ST_READ) && rd_done_raw;

    daq_rd_strobe #(
        .RD_LOW_CYCLES(RD_LOW_CYCLES)
    ) u_rd (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .clr_i  (!en_i),
        .go_i   (rd_go),
        .rd_n_o (rd_n),
        .cap_o  (rd_cap_raw),
        .done_o (rd_done_raw)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next-state: en_i low always wins and returns to IDLE.
    always_comb begin
        state_d = state_q;
        if (!en_i) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:      if (start_i) state_d = ST_ARMED;
                ST_ARMED:     if (tick) state_d = ST_CONVERT;
                ST_CONVERT:   if (conv_end) state_d = ST_WAIT_BUSY;
                ST_WAIT_BUSY: begin
`ifdef DAQ_FRAME_HDR_EN
                    if (busy_ok) state_d = ST_PUSH;
`else
                    if (busy_ok) state_d = ST_READ;
`endif
                    else if (busy_to) state_d = ST_ARMED;
                end
                ST_READ:      if (rd_done) state_d = ST_PUSH;
                ST_PUSH: begin
                    if (accept) begin
                        if (!frame_end)     state_d = ST_READ;
                        else if (burst_end) state_d = ST_IDLE;
                        else                state_d = ST_ARMED;
                    end
                end
                default:      state_d = ST_IDLE;
            endcase
        end
    end

    // Pin and stream handshake levels decoded from the current state.
    always_comb begin
        conv_o    = HI;
        cs_n_o    = HI;
        rd_n_o    = HI;
        m_valid_o = LO;
        unique case (state_q)
            ST_CONVERT: conv_o = LO;
            ST_READ: begin
                cs_n_o = LO;
                rd_n_o = rd_n;
            end
            ST_PUSH: begin
                m_valid_o = HI;
                cs_n_o    = hdr_q ? HI : LO;
            end
            default: ;
        endcase
    end

    // Pacing, phase counters, frame bookkeeping, output word and sticky flags.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            per_q     <= '0;
            force_q   <= 1'b0;
            cnt_q     <= '0;
            ch_q      <= '0;
            burst_q   <= '0;
            frame_q   <= '0;
            hdr_q     <= 1'b0;
            data_q    <= '0;
            last_q    <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else if (!en_i) begin
            per_q     <= '0;
            force_q   <= 1'b0;
            cnt_q     <= '0;
            hdr_q     <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (tick && state_q != ST_ARMED) overrun_q <= 1'b1;
            if (start_ok) begin
                per_q     <= '0;
                force_q   <= 1'b1;
                running_q <= 1'b1;
                burst_q   <= burst_len_i;
                frame_q   <= '0;
            end else if (running_q) begin
                if (force_q)                             force_q <= 1'b0;
                else if (per_q == PW'(PERIOD_CYCLES - 1)) per_q  <= '0;
                else                                     per_q   <= per_q + 1'b1;
            end
            if ((state_q == ST_CONVERT && !conv_end) ||
                (state_q == ST_WAIT_BUSY && !busy_ok && !busy_to))
                cnt_q <= cnt_q + 1'b1;
            else
                cnt_q <= '0;
            if (busy_to) timeout_q <= 1'b1;
            if (busy_ok) begin
                ch_q <= '0;
`ifdef DAQ_FRAME_HDR_EN
                hdr_q  <= 1'b1;
                data_q <= {1'b1, (DATA_W - 1)'(frame_q)};
                last_q <= 1'b0;
`endif
            end
            if (rd_cap) begin
                data_q <= adc_data_i;
                last_q <= (ch_q == CHW'(NUM_CH - 1));
            end
            if (accept) begin
                hdr_q <= 1'b0;
                if (!hdr_q && !word_last) ch_q <= ch_q + 1'b1;
            end
            if (frame_end) frame_q <= frame_nxt;
            if (burst_end) begin
                done_q    <= 1'b1;
                running_q <= 1'b0;
            end
        end
    end

    assign m_data_o  = data_q;
    assign m_last_o  = last_q;
    assign running_o = running_q;
    assign done_o    = done_q;
    assign overrun_o = overrun_q;
    assign timeout_o = timeout_q;

endmodule
